capture_ctrl: RTL and testbench
===============================

// Module: capture_ctrl
// PURPOSE
//  Capture sequencer for the logic analyzer. It fills the circular sample RAM with pre-trigger data,
//  then drives 'armed' to every chan_trig instance. It ANDs the per-channel and protocol triggers,
//  counts trig_pos post-trigger samples and flags capture_done. Sits between the command decoder and the sample RAM.
// PARAMETERS
//  NUM_CH  5  number of chan_trig instances feeding chan_trig[]
//  ADDR_W  9  sample RAM address width; DEPTH = 2**ADDR_W (localparam)
// PORTS
//  clk           in   1        system clock; all logic on posedge
//  rst           in   1        asynchronous, active-high reset
//  start         in   1        1-cycle pulse from cmd decoder: begin capture
//  abort         in   1        1-cycle pulse: cancel capture, return to IDLE
//  smpl_en       in   1        decimated sample strobe; one RAM write per strobe while capturing
//  trig_pos      in   ADDR_W   post-trigger sample count; latched on start
//  chan_trig     in   NUM_CH   CHxTrig from each chan_trig (1 = channel condition met or don't-care)
//  prot_trig     in   1        protocol trigger (UART/SPI); tie high if unused
//  armed         out  1        to chan_trig.armed; low clears their edge latches
//  we            out  1        RAM write enable
//  waddr         out  ADDR_W   RAM write address
//  trig_addr     out  ADDR_W   address of first post-trigger sample
//  triggered     out  1        sticky: trigger accepted this run
//  capture_done  out  1        capture complete; RAM content is stable
//  busy          out  1        state in {PRE, ARMED, POST}
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; waddr=0, trig_addr=0, all counters=0.
//  States: IDLE, PRE, ARMED, POST, DONE. abort wins over every other event, including start in the same cycle.
//   abort action: ->IDLE, armed=0, triggered=0, capture_done=0. waddr and trig_addr hold.
//  Start action: tp_l <= min(trig_pos, DEPTH-1); pre_cnt=0; waddr=0; triggered=0;
//   capture_done=0; -> PRE. Accepted in IDLE and DONE; ignored in PRE/ARMED/POST.
//  we = smpl_en & busy (combinational). Each write uses the current waddr.
//   The following edge does waddr <= waddr+1 mod DEPTH (wraps DEPTH-1 -> 0).
//  PRE: each write does pre_cnt++. A write with pre_cnt == DEPTH-tp_l-1 -> ARMED, armed<=1 on that edge.
//   The pre-trigger region is full before chan_trig may latch edges.
//  ARMED: writes continue circularly. trig_q <= armed & (&chan_trig) & prot_trig (registered).
//   When trig_q=1: trig_addr <= waddr (+1 if we same cycle); triggered<=1; post_cnt=0;
//   -> POST if tp_l!=0, else -> DONE.
//   Latency: chan_trig/prot_trig all high at edge N -> trig_q at N+1 -> state change at N+2.
//  POST: each write does post_cnt++. A write with post_cnt == tp_l-1 -> DONE.
//  DONE: we=0, armed=0, capture_done=1 and held until start or abort; waddr frozen.
//  armed=1 exactly in ARMED and POST. trig_q is forced to 0 whenever armed=0.
//  Counters are ADDR_W bits wide; the tp_l clamp guarantees no overflow.
//  trig_pos changes mid-run have no effect.
// STRUCTURE
//  la_pkg (shared): typedef enum logic [2:0] {IDLE,PRE,ARMED,POST,DONE} cap_state_t.
//   Also in la_pkg: localparam for the default ADDR_W.
//  Single flat module, no sub-module: one FSM, three counters (waddr, pre_cnt, post_cnt), trig_q flop.
// TESTING (ADDR_W=4, DEPTH=16, NUM_CH=5, smpl_en every cycle unless stated)
//  1. start with trig_pos=6 -> busy next edge.
//     we on waddr 0..9; armed rises on the edge after the write to 9.
//     No trigger -> waddr wraps 15->0 and keeps writing.
//  2. Continue 1: chan_trig=5'h1F, prot_trig=1 at waddr=3 -> trig_addr=4 or 5 per latency rule.
//     Then exactly 6 writes, capture_done=1, we=0, armed=0.
//  3. ARMED with chan_trig=5'h1E (one channel low), prot_trig=1 for 50 cycles -> no trigger, triggered=0.
//  4. trig_pos=0 -> armed after 16 writes; trigger -> DONE with zero post writes.
//     trig_pos=20 -> clamped to 15, armed after 1 write.
//  5. start and abort same cycle in IDLE -> stays IDLE.
//     abort in POST -> IDLE next edge, armed=0, capture_done=0.
//  6. rst asserted mid-POST with smpl_en toggling -> all outputs 0 immediately (asynchronous).
//     After release, start works normally; smpl_en=1 every 3rd cycle -> writes only on strobes.

Source files
------------

// File: rtl/la_pkg.sv
// la_pkg: definitions shared across the logic analyzer blocks.
//   cap_state_t  : capture sequencer state encoding
//   LA_ADDR_W    : default sample RAM address width
//   LA_NUM_CH    : default number of channel trigger units
package la_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE   = 3'd1,
    ARMED = 3'd2,
    POST  = 3'd3,
    DONE  = 3'd4
  } cap_state_t;

  localparam int LA_ADDR_W = 9;
  localparam int LA_NUM_CH = 5;

endpackage

// File: rtl/capture_ctrl.sv
// capture_ctrl: capture sequencer for the logic analyzer.
//
// Fills the circular sample RAM with pre-trigger data, then arms the channel
// trigger units. Once every channel condition and the protocol trigger agree,
// it records where the post-trigger data starts, writes trig_pos more samples
// and reports capture_done.
//
// Ports
//   clk          : system clock, all logic on posedge
//   rst          : asynchronous, active-high reset
//   start        : 1-cycle pulse, begin a capture (honoured in IDLE and DONE)
//   abort        : 1-cycle pulse, cancel and return to IDLE (beats start)
//   smpl_en      : decimated sample strobe, one RAM write per strobe while busy
//   trig_pos     : post-trigger sample count, latched on an accepted start
//   chan_trig    : per-channel trigger condition (1 = met or don't-care)
//   prot_trig    : protocol trigger, tie high if unused
//   armed        : to chan_trig units; low clears their edge latches
//   we           : RAM write enable
//   waddr        : RAM write address
//   trig_addr    : address of the first post-trigger sample
//   triggered    : sticky, trigger accepted during this run
//   capture_done : capture complete, RAM content stable
//   busy         : state is PRE, ARMED or POST
//   state_dbg    : current sequencer state, for observation only
//
// Interface timing: start and abort are single-cycle command pulses with no
// handshake; they act on the rising edge where they are sampled high. A RAM
// write happens on every cycle where we=1, at the address shown on waddr in
// that same cycle; waddr advances on the following edge.
module capture_ctrl
  import la_pkg::*;
#(
  parameter int NUM_CH = LA_NUM_CH,
  parameter int ADDR_W = LA_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              smpl_en,
  input  logic [ADDR_W-1:0] trig_pos,
  input  logic [NUM_CH-1:0] chan_trig,
  input  logic              prot_trig,
  output logic              armed,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              triggered,
  output logic              capture_done,
  output logic              busy,
  output cap_state_t        state_dbg
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

  cap_state_t        state;
  cap_state_t        state_nxt;

  logic [ADDR_W-1:0] tp_l;
  logic [ADDR_W-1:0] pre_cnt;
  logic [ADDR_W-1:0] post_cnt;
  logic [ADDR_W-1:0] pre_last;
  logic [ADDR_W-1:0] post_last;
  logic              trig_q;
  logic              trig_fire;
  logic              start_ok;

  // Status outputs decode straight from the state register, so an async
  // reset drops them in the same instant it clears the state.
  assign busy         = (state == PRE) || (state == ARMED) || (state == POST);
  assign armed        = (state == ARMED) || (state == POST);
  assign capture_done = (state == DONE);
  assign we           = smpl_en & busy;
  assign state_dbg    = state;

  // The pre-trigger region holds DEPTH - tp_l samples; the last of them is
  // written when pre_cnt reaches DEPTH-1-tp_l. trig_pos is ADDR_W bits wide,
  // so it never exceeds DEPTH-1 and latching it unchanged keeps the counters
  // within range.
  assign pre_last  = LAST_ADDR - tp_l;
  assign post_last = tp_l - ONE;

  // A start is only honoured when no capture is running, and never together
  // with an abort.
  assign start_ok  = start && !abort && ((state == IDLE) || (state == DONE));

  // trig_q is registered one cycle before it is acted on; it only counts
  // while we are still waiting in ARMED.
  assign trig_fire = trig_q && (state == ARMED);

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) state_nxt = PRE;
        end
        PRE: begin
          if (we && (pre_cnt == pre_last)) state_nxt = ARMED;
        end
        ARMED: begin
          if (trig_fire) state_nxt = (tp_l != '0) ? POST : DONE;
        end
        POST: begin
          if (we && (post_cnt == post_last)) state_nxt = DONE;
        end
        DONE: begin
          if (start) state_nxt = PRE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Datapath: address, counters, trigger capture
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tp_l      <= '0;
      pre_cnt   <= '0;
      post_cnt  <= '0;
      waddr     <= '0;
      trig_addr <= '0;
      trig_q    <= 1'b0;
      triggered <= 1'b0;
    end else if (abort) begin
      // Address registers keep their values so the host can still inspect
      // where the aborted run stopped.
      trig_q    <= 1'b0;
      triggered <= 1'b0;
    end else if (start_ok) begin
      tp_l      <= trig_pos;
      pre_cnt   <= '0;
      post_cnt  <= '0;
      waddr     <= '0;
      trig_q    <= 1'b0;
      triggered <= 1'b0;
    end else begin
      // Natural ADDR_W-bit wrap gives the circular addressing.
      if (we) begin
        waddr <= waddr + ONE;
      end

      if ((state == PRE) && we) begin
        pre_cnt <= pre_cnt + ONE;
      end

      trig_q <= armed & (&chan_trig) & prot_trig;

      if (trig_fire) begin
        // If a write lands in the same cycle, the next sample is the first
        // one that belongs to the post-trigger region.
        trig_addr <= waddr + (we ? ONE : '0);
        triggered <= 1'b1;
        post_cnt  <= '0;
      end else if ((state == POST) && we) begin
        post_cnt <= post_cnt + ONE;
      end
    end
  end

endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl: directed bench for capture_ctrl with ADDR_W=4 (DEPTH=16)
// and NUM_CH=5. Inputs change 1 time unit after each rising edge; outputs are
// compared at that point or 1 time unit later, well away from the next edge.
module tb_capture_ctrl;
  import la_pkg::*;

  localparam int AW = 4;
  localparam int NC = 5;

  logic          clk;
  logic          rst;
  logic          start;
  logic          abort;
  logic          smpl_en;
  logic [AW-1:0] trig_pos;
  logic [NC-1:0] chan_trig;
  logic          prot_trig;
  logic          armed;
  logic          we;
  logic [AW-1:0] waddr;
  logic [AW-1:0] trig_addr;
  logic          triggered;
  logic          capture_done;
  logic          busy;
  cap_state_t    state_dbg;

  int errors = 0;
  int checks = 0;
  int wa;

  capture_ctrl #(.NUM_CH(NC), .ADDR_W(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .smpl_en      (smpl_en),
    .trig_pos     (trig_pos),
    .chan_trig    (chan_trig),
    .prot_trig    (prot_trig),
    .armed        (armed),
    .we           (we),
    .waddr        (waddr),
    .trig_addr    (trig_addr),
    .triggered    (triggered),
    .capture_done (capture_done),
    .busy         (busy),
    .state_dbg    (state_dbg)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Driver helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_armed"}, 32'(armed), 0);
    chk({tag, "_we"},    32'(we), 0);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_done"},  32'(capture_done), 0);
    chk({tag, "_trgd"},  32'(triggered), 0);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    smpl_en   = 1'b0;
    trig_pos  = '0;
    chan_trig = '0;
    prot_trig = 1'b0;
    repeat (3) tick();

    // ---- reset state ----
    chk_idle_outputs("reset");
    chk("reset_waddr", 32'(waddr), 0);
    chk("reset_taddr", 32'(trig_addr), 0);
    chk("reset_state", 32'(state_dbg), 32'(IDLE));
    rst = 1'b0;
    tick();
    chk("idle_state", 32'(state_dbg), 32'(IDLE));

    // ---- 1: pre-trigger fill with trig_pos=6, then circular writes ----
    trig_pos = 4'd6;
    smpl_en  = 1'b1;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    chk("t1_busy", 32'(busy), 1);
    chk("t1_we", 32'(we), 1);
    chk("t1_waddr0", 32'(waddr), 0);
    chk("t1_armed0", 32'(armed), 0);
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk("t1_pre_waddr", 32'(waddr), 32'(i));
      chk("t1_pre_armed", 32'(armed), 0);
    end
    tick();
    chk("t1_armed", 32'(armed), 1);
    chk("t1_waddr10", 32'(waddr), 10);
    chk("t1_state", 32'(state_dbg), 32'(ARMED));
    repeat (6) tick();
    chk("t1_wrap", 32'(waddr), 0);
    chk("t1_notrig", 32'(triggered), 0);
    chk("t1_wrap_we", 32'(we), 1);
    repeat (3) tick();
    chk("t1_waddr3", 32'(waddr), 3);

    // ---- 2: trigger at waddr=3, then six post-trigger writes ----
    chan_trig = 5'h1F;
    prot_trig = 1'b1;
    tick();
    chk("t2_lat_state", 32'(state_dbg), 32'(ARMED));
    chk("t2_lat_trgd", 32'(triggered), 0);
    chk("t2_lat_waddr", 32'(waddr), 4);
    tick();
    chk("t2_state", 32'(state_dbg), 32'(POST));
    chk("t2_taddr", 32'(trig_addr), 5);
    chk("t2_trgd", 32'(triggered), 1);
    chk("t2_waddr", 32'(waddr), 5);
    chan_trig = '0;
    repeat (5) tick();
    chk("t2_post5_done", 32'(capture_done), 0);
    chk("t2_post5_waddr", 32'(waddr), 10);
    tick();
    chk("t2_done", 32'(capture_done), 1);
    chk("t2_done_we", 32'(we), 0);
    chk("t2_done_armed", 32'(armed), 0);
    chk("t2_done_busy", 32'(busy), 0);
    chk("t2_done_waddr", 32'(waddr), 11);
    repeat (2) tick();
    chk("t2_hold_done", 32'(capture_done), 1);
    chk("t2_hold_waddr", 32'(waddr), 11);
    chk("t2_hold_taddr", 32'(trig_addr), 5);
    chk("t2_hold_trgd", 32'(triggered), 1);

    // ---- 3: one channel low keeps the trigger off ----
    chan_trig = 5'h1E;
    prot_trig = 1'b1;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    chk("t3_restart_waddr", 32'(waddr), 0);
    chk("t3_restart_done", 32'(capture_done), 0);
    chk("t3_restart_trgd", 32'(triggered), 0);
    repeat (10) tick();
    chk("t3_armed", 32'(armed), 1);
    repeat (50) tick();
    chk("t3_notrig", 32'(triggered), 0);
    chk("t3_state", 32'(state_dbg), 32'(ARMED));
    chk("t3_waddr", 32'(waddr), 12);
    // All channels met but protocol trigger low: still no trigger.
    chan_trig = 5'h1F;
    prot_trig = 1'b0;
    repeat (5) tick();
    chk("t3_prot_low", 32'(triggered), 0);
    chk("t3_prot_waddr", 32'(waddr), 1);
    // start while busy is ignored.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t3_start_ign", 32'(waddr), 2);
    chk("t3_start_ign_st", 32'(state_dbg), 32'(ARMED));

    // ---- 5b: trigger, then abort in POST ----
    prot_trig = 1'b1;
    repeat (2) tick();
    chk("t5_post", 32'(state_dbg), 32'(POST));
    chk("t5_taddr", 32'(trig_addr), 4);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_idle_outputs("t5_abort");
    chk("t5_abort_state", 32'(state_dbg), 32'(IDLE));
    chk("t5_abort_waddr", 32'(waddr), 4);
    chk("t5_abort_taddr", 32'(trig_addr), 4);

    // ---- 5a: start and abort together in IDLE ----
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("t5_both_state", 32'(state_dbg), 32'(IDLE));
    chk("t5_both_busy", 32'(busy), 0);
    chk("t5_both_waddr", 32'(waddr), 4);

    // ---- 4a: trig_pos=0 -> 16 pre writes, trigger goes straight to DONE ----
    chan_trig = '0;
    trig_pos  = 4'd0;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    repeat (15) tick();
    chk("t4_pre15_armed", 32'(armed), 0);
    chk("t4_pre15_waddr", 32'(waddr), 15);
    tick();
    chk("t4_armed", 32'(armed), 1);
    chk("t4_wrap", 32'(waddr), 0);
    chan_trig = 5'h1F;
    tick();
    chk("t4_lat_state", 32'(state_dbg), 32'(ARMED));
    tick();
    chk("t4_done", 32'(capture_done), 1);
    chk("t4_trgd", 32'(triggered), 1);
    chk("t4_taddr", 32'(trig_addr), 2);
    chk("t4_waddr", 32'(waddr), 2);
    chk("t4_we", 32'(we), 0);

    // ---- 4b: largest trig_pos -> armed after one write ----
    trig_pos = 4'd15;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    chk("t4b_pre_armed", 32'(armed), 0);
    trig_pos = 4'd3; // mid-run change must not matter
    tick();
    chk("t4b_armed", 32'(armed), 1);
    chk("t4b_waddr", 32'(waddr), 1);
    repeat (2) tick();
    chk("t4b_post", 32'(state_dbg), 32'(POST));
    chk("t4b_taddr", 32'(trig_addr), 3);

    // ---- 6: async reset mid-POST with smpl_en toggling ----
    chan_trig = '0;
    smpl_en = 1'b0;
    tick();
    chk("t6_hold_waddr", 32'(waddr), 3);
    smpl_en = 1'b1;
    tick();
    chk("t6_step_waddr", 32'(waddr), 4);
    chk("t6_still_post", 32'(state_dbg), 32'(POST));
    rst = 1'b1;
    #1;
    chk_idle_outputs("t6_rst");
    chk("t6_rst_waddr", 32'(waddr), 0);
    chk("t6_rst_taddr", 32'(trig_addr), 0);
    tick();
    rst = 1'b0;
    tick();

    // Restart with smpl_en every 3rd cycle.
    trig_pos = 4'd2;
    smpl_en  = 1'b0;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    chk("t6_busy", 32'(busy), 1);
    wa = 0;
    for (int c = 0; c < 9; c++) begin
      smpl_en = (c % 3 == 0);
      #1;
      chk("t6_we", 32'(we), 32'(c % 3 == 0));
      tick();
      if (c % 3 == 0) wa = (wa + 1) % 16;
      chk("t6_waddr", 32'(waddr), 32'(wa));
    end
    chk("t6_final_waddr", 32'(waddr), 3);
    chk("t6_final_armed", 32'(armed), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
